alu_seq: RTL and testbench

Parametrised, sequential successor to the 4-bit combinational ALU. It adds registered outputs, status flags, and a valid/ready handshake on both sides. It also adds two multi-cycle operations: an iterative shift-left by a variable amount, and a shift-add multiply. The block sits between an operand source (register file or test sequencer) and a result consumer, and processes one operation at a time.

---
 rtl/alu_seq_if.sv | 28 ++
 rtl/alu_seq.sv | 175 +++++++++++++++++
 tb/tb_alu_seq.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/alu_seq_if.sv
// Operand/result handshake bundle for alu_seq: valid/ready on the operand side
// and on the result side, plus the registered result and status flags.
interface alu_seq_if #(
  parameter int unsigned WIDTH = 4
);
  logic [2:0]       ALU_option;
  logic [WIDTH-1:0] ALU_in1;
  logic [WIDTH-1:0] ALU_in2;
  logic             ALU_in_valid;
  logic             ALU_in_ready;
  logic [WIDTH-1:0] ALU_out;
  logic             ALU_Cout;
  logic             ALU_zero;
  logic             ALU_neg;
  logic             ALU_ovf;
  logic             ALU_out_valid;
  logic             ALU_out_ready;

  modport master (
    output ALU_option, ALU_in1, ALU_in2, ALU_in_valid, ALU_out_ready,
    input  ALU_in_ready, ALU_out, ALU_Cout, ALU_zero, ALU_neg, ALU_ovf, ALU_out_valid
  );

  modport slave (
    input  ALU_option, ALU_in1, ALU_in2, ALU_in_valid, ALU_out_ready,
    output ALU_in_ready, ALU_out, ALU_Cout, ALU_zero, ALU_neg, ALU_ovf, ALU_out_valid
  );
endinterface

// File: rtl/alu_seq.sv
// Sequential ALU with registered result/flags, valid/ready handshakes and two
// iterative ops: bit-serial shift-left and shift-add multiply.
module alu_seq #(
  parameter int unsigned WIDTH = 4
) (
  input logic     ALU_clk,
  input logic     ALU_reset,
  alu_seq_if.slave bus
);
  localparam int unsigned CntW = $clog2(WIDTH + 1);

  localparam logic [2:0] OpAdd = 3'b000;
  localparam logic [2:0] OpSub = 3'b001;
  localparam logic [2:0] OpAnd = 3'b010;
  localparam logic [2:0] OpOr  = 3'b011;
  localparam logic [2:0] OpNot = 3'b100;
  localparam logic [2:0] OpXor = 3'b101;
  localparam logic [2:0] OpShl = 3'b110;
  localparam logic [2:0] OpMul = 3'b111;

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e             state_q, state_d;
  logic [2:0]         op_q;
  logic [CntW-1:0]    cnt_q;
  logic [WIDTH-1:0]   shreg_q;
  logic               sh_cout_q;
  logic [WIDTH-1:0]   mcand_q;
  logic [2*WIDTH-1:0] prod_q;
  logic [WIDTH-1:0]   out_q;
  logic               cout_q, zero_q, neg_q, ovf_q;

  logic               in_ready, accept, go_busy, last;
  logic [CntW-1:0]    sh_amt;
  logic [WIDTH:0]     sum_w, diff_w;
  logic [WIDTH-1:0]   sc_res;
  logic               sc_cout, sc_ovf;
  logic [WIDTH-1:0]   sh_next;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] prod_next;
  logic               load_en;
  logic [WIDTH-1:0]   load_res;
  logic               load_cout, load_ovf;

  assign accept = bus.ALU_in_valid && in_ready;
  assign last   = (cnt_q == CntW'(1));

  // Shift amount saturates at WIDTH; larger B just clears the operand.
  always_comb begin
    sh_amt = CntW'(bus.ALU_in2);
    if (32'(bus.ALU_in2) >= WIDTH) sh_amt = CntW'(WIDTH);
  end

  assign go_busy = (bus.ALU_option == OpMul) ||
                   ((bus.ALU_option == OpShl) && (sh_amt != '0));

  always_comb begin
    sum_w   = {1'b0, bus.ALU_in1} + {1'b0, bus.ALU_in2};
    diff_w  = {1'b0, bus.ALU_in1} - {1'b0, bus.ALU_in2};
    sc_res  = bus.ALU_in1;
    sc_cout = 1'b0;
    sc_ovf  = 1'b0;
    unique case (bus.ALU_option)
      OpAdd: begin
        sc_res  = sum_w[WIDTH-1:0];
        sc_cout = sum_w[WIDTH];
        sc_ovf  = (bus.ALU_in1[WIDTH-1] == bus.ALU_in2[WIDTH-1]) &&
                  (sum_w[WIDTH-1] != bus.ALU_in1[WIDTH-1]);
      end
      OpSub: begin
        sc_res  = diff_w[WIDTH-1:0];
        sc_cout = diff_w[WIDTH];
        sc_ovf  = (bus.ALU_in1[WIDTH-1] != bus.ALU_in2[WIDTH-1]) &&
                  (diff_w[WIDTH-1] != bus.ALU_in1[WIDTH-1]);
      end
      OpAnd:   sc_res = bus.ALU_in1 & bus.ALU_in2;
      OpOr:    sc_res = bus.ALU_in1 | bus.ALU_in2;
      OpNot:   sc_res = ~bus.ALU_in1;
      OpXor:   sc_res = bus.ALU_in1 ^ bus.ALU_in2;
      default: sc_res = bus.ALU_in1;
    endcase
  end

  // Multiplier keeps {partial_hi, multiplier_lo} and shifts right once per step.
  always_comb begin
    sh_next   = {shreg_q[WIDTH-2:0], 1'b0};
    mul_sum   = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (prod_q[0] ? {1'b0, mcand_q} : '0);
    prod_next = {mul_sum, prod_q[WIDTH-1:1]};
  end

  always_comb begin
    load_en   = 1'b0;
    load_res  = sc_res;
    load_cout = sc_cout;
    load_ovf  = sc_ovf;
    if (accept && !go_busy) begin
      load_en = 1'b1;
    end else if (state_q == StBusy && last) begin
      load_en  = 1'b1;
      load_ovf = 1'b0;
      if (op_q == OpMul) begin
        load_res  = prod_next[WIDTH-1:0];
        load_cout = |prod_next[2*WIDTH-1:WIDTH];
      end else begin
        load_res  = sh_next;
        load_cout = shreg_q[WIDTH-1];
      end
    end
  end

  always_ff @(posedge ALU_clk) begin
    if (ALU_reset) state_q <= StIdle;
    else           state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (accept) state_d = go_busy ? StBusy : StDone;
      StBusy:  if (last) state_d = StDone;
      StDone:  if (bus.ALU_out_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    in_ready          = (state_q == StIdle) && !ALU_reset;
    bus.ALU_in_ready  = in_ready;
    bus.ALU_out_valid = (state_q == StDone);
  end

  always_ff @(posedge ALU_clk) begin
    if (ALU_reset) begin
      op_q      <= '0;
      cnt_q     <= '0;
      shreg_q   <= '0;
      sh_cout_q <= 1'b0;
      mcand_q   <= '0;
      prod_q    <= '0;
      out_q     <= '0;
      cout_q    <= 1'b0;
      zero_q    <= 1'b0;
      neg_q     <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      if (accept) begin
        op_q      <= bus.ALU_option;
        cnt_q     <= (bus.ALU_option == OpMul) ? CntW'(WIDTH) : sh_amt;
        shreg_q   <= bus.ALU_in1;
        sh_cout_q <= 1'b0;
        mcand_q   <= bus.ALU_in1;
        prod_q    <= {{WIDTH{1'b0}}, bus.ALU_in2};
      end else if (state_q == StBusy) begin
        cnt_q     <= cnt_q - CntW'(1);
        shreg_q   <= sh_next;
        sh_cout_q <= shreg_q[WIDTH-1];
        prod_q    <= prod_next;
      end
      if (load_en) begin
        out_q  <= load_res;
        cout_q <= load_cout;
        zero_q <= (load_res == '0);
        neg_q  <= load_res[WIDTH-1];
        ovf_q  <= load_ovf;
      end
    end
  end

  assign bus.ALU_out  = out_q;
  assign bus.ALU_Cout = cout_q;
  assign bus.ALU_zero = zero_q;
  assign bus.ALU_neg  = neg_q;
  assign bus.ALU_ovf  = ovf_q;

endmodule

// File: tb/tb_alu_seq.sv
// Directed and model-based checks of alu_seq at WIDTH=4 and WIDTH=8.
module tb_alu_seq;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  alu_seq_if #(.WIDTH(4)) b4();
  alu_seq_if #(.WIDTH(8)) b8();

  alu_seq #(.WIDTH(4)) dut4 (.ALU_clk(clk), .ALU_reset(rst), .bus(b4.slave));
  alu_seq #(.WIDTH(8)) dut8 (.ALU_clk(clk), .ALU_reset(rst), .bus(b8.slave));

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic op4(input string tag, input logic [2:0] op, input logic [3:0] a,
                     input logic [3:0] b, input logic [3:0] e_out, input logic e_c,
                     input logic e_ovf, input int e_lat);
    int lat;
    @(negedge clk);
    b4.ALU_option = op; b4.ALU_in1 = a; b4.ALU_in2 = b; b4.ALU_in_valid = 1'b1;
    check({tag, ".in_rdy"}, 32'(b4.ALU_in_ready), 1);
    @(posedge clk); #1;
    b4.ALU_in_valid = 1'b0;
    lat = 1;
    while (!b4.ALU_out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, ".lat"}, 32'(lat), 32'(e_lat));
    check({tag, ".out"}, 32'(b4.ALU_out), 32'(e_out));
    check({tag, ".cout"}, 32'(b4.ALU_Cout), 32'(e_c));
    check({tag, ".ovf"}, 32'(b4.ALU_ovf), 32'(e_ovf));
    check({tag, ".zero"}, 32'(b4.ALU_zero), 32'(e_out == 4'd0));
    check({tag, ".neg"}, 32'(b4.ALU_neg), 32'(e_out[3]));
    @(negedge clk); b4.ALU_out_ready = 1'b1;
    @(posedge clk); #1; b4.ALU_out_ready = 1'b0;
    check({tag, ".vld_fall"}, 32'(b4.ALU_out_valid), 0);
    check({tag, ".rdy_rise"}, 32'(b4.ALU_in_ready), 1);
  endtask

  task automatic op8(input string tag, input logic [2:0] op, input logic [7:0] a,
                     input logic [7:0] b, input logic [7:0] e_out, input logic e_c,
                     input logic e_ovf, input int e_lat);
    int lat;
    @(negedge clk);
    b8.ALU_option = op; b8.ALU_in1 = a; b8.ALU_in2 = b; b8.ALU_in_valid = 1'b1;
    @(posedge clk); #1;
    b8.ALU_in_valid = 1'b0;
    lat = 1;
    while (!b8.ALU_out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, ".lat"}, 32'(lat), 32'(e_lat));
    check({tag, ".out"}, 32'(b8.ALU_out), 32'(e_out));
    check({tag, ".cout"}, 32'(b8.ALU_Cout), 32'(e_c));
    check({tag, ".ovf"}, 32'(b8.ALU_ovf), 32'(e_ovf));
    check({tag, ".zero"}, 32'(b8.ALU_zero), 32'(e_out == 8'd0));
    check({tag, ".neg"}, 32'(b8.ALU_neg), 32'(e_out[7]));
    @(negedge clk); b8.ALU_out_ready = 1'b1;
    @(posedge clk); #1; b8.ALU_out_ready = 1'b0;
  endtask

  // Returns {lat[7:0], ovf, cout, out[7:0]}.
  function automatic logic [17:0] ref8(input logic [2:0] op, input logic [7:0] a,
                                       input logic [7:0] b);
    logic [8:0]  s;
    logic [15:0] t;
    logic [7:0]  o;
    logic        c, v;
    int          n, lat;
    o = 8'd0; c = 1'b0; v = 1'b0; lat = 1;
    case (op)
      3'b000: begin s = {1'b0, a} + {1'b0, b}; o = s[7:0]; c = s[8];
                    v = (a[7] == b[7]) && (o[7] != a[7]); end
      3'b001: begin s = {1'b0, a} - {1'b0, b}; o = s[7:0]; c = s[8];
                    v = (a[7] != b[7]) && (o[7] != a[7]); end
      3'b010: o = a & b;
      3'b011: o = a | b;
      3'b100: o = ~a;
      3'b101: o = a ^ b;
      3'b110: begin
        n = (b >= 8'd8) ? 8 : int'(b);
        t = 16'(a) << n;
        o = t[7:0];
        c = (n == 0) ? 1'b0 : t[8];
        lat = 1 + n;
      end
      default: begin t = 16'(a) * 16'(b); o = t[7:0]; c = |t[15:8]; lat = 9; end
    endcase
    return {8'(lat), v, c, o};
  endfunction

  initial begin
    logic        saw;
    logic [17:0] r;
    logic [2:0]  op;
    logic [7:0]  a, b;
    b4.ALU_option = '0; b4.ALU_in1 = '0; b4.ALU_in2 = '0;
    b4.ALU_in_valid = 1'b0; b4.ALU_out_ready = 1'b0;
    b8.ALU_option = '0; b8.ALU_in1 = '0; b8.ALU_in2 = '0;
    b8.ALU_in_valid = 1'b0; b8.ALU_out_ready = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    check("rst.out", 32'(b4.ALU_out), 0);
    check("rst.vld", 32'(b4.ALU_out_valid), 0);
    check("rst.in_rdy", 32'(b4.ALU_in_ready), 0);
    @(negedge clk); rst = 1'b0;
    #1 check("rst.in_rdy_after", 32'(b4.ALU_in_ready), 1);

    op4("add_ovf", 3'b000, 4'b0111, 4'b0001, 4'b1000, 1'b0, 1'b1, 1);
    op4("sub_brw", 3'b001, 4'b0011, 4'b0101, 4'b1110, 1'b1, 1'b0, 1);
    op4("add_zero", 3'b000, 4'b1000, 4'b1000, 4'b0000, 1'b1, 1'b1, 1);

    // Abort a multiply mid-flight with reset.
    @(negedge clk);
    b4.ALU_option = 3'b111; b4.ALU_in1 = 4'd3; b4.ALU_in2 = 4'd5; b4.ALU_in_valid = 1'b1;
    @(posedge clk); #1 b4.ALU_in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk); rst = 1'b1;
    #1 check("abort.in_rdy_comb", 32'(b4.ALU_in_ready), 0);
    @(posedge clk); #1;
    check("abort.out", 32'(b4.ALU_out), 0);
    check("abort.cout", 32'(b4.ALU_Cout), 0);
    check("abort.zero", 32'(b4.ALU_zero), 0);
    check("abort.ovf", 32'(b4.ALU_ovf), 0);
    check("abort.vld", 32'(b4.ALU_out_valid), 0);
    check("abort.in_rdy", 32'(b4.ALU_in_ready), 0);
    @(negedge clk); rst = 1'b0;
    #1 check("abort.in_rdy_after", 32'(b4.ALU_in_ready), 1);
    saw = 1'b0;
    repeat (8) begin
      @(posedge clk); #1 saw = saw | b4.ALU_out_valid;
    end
    check("abort.no_pulse", 32'(saw), 0);

    op4("shl2", 3'b110, 4'b1011, 4'd2, 4'b1100, 1'b0, 1'b0, 3);
    op4("shl0", 3'b110, 4'b1011, 4'd0, 4'b1011, 1'b0, 1'b0, 1);
    op4("shl9", 3'b110, 4'b1011, 4'd9, 4'b0000, 1'b1, 1'b0, 5);
    op4("mul3x5", 3'b111, 4'b0011, 4'b0101, 4'b1111, 1'b0, 1'b0, 5);
    op4("mulFxF", 3'b111, 4'b1111, 4'b1111, 4'b0001, 1'b1, 1'b0, 5);
    op4("not", 3'b100, 4'b0101, 4'b0000, 4'b1010, 1'b0, 1'b0, 1);

    // Backpressure: result must hold while new requests are offered.
    @(negedge clk);
    b4.ALU_option = 3'b101; b4.ALU_in1 = 4'b1010; b4.ALU_in2 = 4'b0110; b4.ALU_in_valid = 1'b1;
    @(posedge clk); #1 b4.ALU_in_valid = 1'b0;
    check("bp.vld", 32'(b4.ALU_out_valid), 1);
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      b4.ALU_option = 3'b000; b4.ALU_in1 = 4'd1; b4.ALU_in2 = 4'd1; b4.ALU_in_valid = 1'b1;
      @(posedge clk); #1;
      check($sformatf("bp.out%0d", i), 32'(b4.ALU_out), 32'hC);
      check($sformatf("bp.hold%0d", i), {30'd0, b4.ALU_out_valid, b4.ALU_in_ready}, 32'h2);
    end
    @(negedge clk); b4.ALU_in_valid = 1'b0; b4.ALU_out_ready = 1'b1;
    @(posedge clk); #1 b4.ALU_out_ready = 1'b0;
    check("bp.release", {30'd0, b4.ALU_out_valid, b4.ALU_in_ready}, 32'h1);
    op4("post_bp", 3'b000, 4'd1, 4'd1, 4'd2, 1'b0, 1'b0, 1);

    op8("mul200x3", 3'b111, 8'd200, 8'd3, 8'h58, 1'b1, 1'b0, 9);
    for (int i = 0; i < 30; i++) begin
      op = 3'($urandom_range(0, 7));
      a  = 8'($urandom);
      b  = (op == 3'b110) ? 8'($urandom_range(0, 12)) : 8'($urandom);
      r  = ref8(op, a, b);
      op8($sformatf("rnd%0d_op%0d", i, op), op, a, b, r[7:0], r[8], r[9], int'(r[17:10]));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
